// File: rtl/prio_event_encoder.sv
// Registered N-line priority encoder: sticky pending capture, one event at a time
// out over valid/ready, fixed-priority (RR=0) or round-robin (RR=1) selection.
module prio_event_encoder #(
    parameter  int N  = 8,
    parameter  int RR = 0,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         ovf
);

    logic [W-1:0] sel;
    logic [W-1:0] last;
    logic [N-1:0] take_mask;
    logic         slot_free;
    logic         load;
    logic         found;
    int unsigned  idx;

    assign slot_free = !out_valid || out_ready;
    assign load      = slot_free && (|pending) && !clr;

    // Selection looks only at registered pending; same-cycle requests wait an edge.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        if (RR == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (pending[W'(i)]) sel = W'(i);
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = 32'(last) + k;
                if (idx >= N) idx = idx - N;
                if (!found && pending[W'(idx)]) begin
                    sel   = W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        take_mask = '0;
        if (load) take_mask[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            last      <= W'(N - 1);
        end else begin
            // Re-arming a bit on the edge it is taken is a fresh event, not a loss.
            if (clr) begin
                pending <= '0;
                ovf     <= 1'b0;
            end else begin
                pending <= (pending & ~take_mask) | req_i;
                if (|(req_i & pending & ~take_mask)) ovf <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= sel;
                last      <= sel;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
